// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the raster timing generator.
//   timing_t      : the eight horizontal/vertical timing fields (pixels / lines)
//   VGA_640x480   : default 640x480@60 timing
//   vtg_state_e   : sequencer states of video_timing_gen
//   BAR_*         : RGB888 colours of the eight test-pattern bars
//   bar_colour()  : bar index (0 = leftmost) to RGB888
// -----------------------------------------------------------------------------
package video_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_active;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
    } timing_t;

    localparam timing_t VGA_640x480 = '{
        h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_active: 480, v_front: 10, v_sync: 2,  v_back: 33
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } vtg_state_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Up-counter that wraps from Max back to 0.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   inc_i   : advance by one
//   clr_i   : synchronous clear to 0 (has priority over inc_i)
//   cnt_o   : current count
//   wrap_o  : high when this increment takes the count from Max to 0
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int Width = 12,
    parameter int Max   = 799
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    logic [Width-1:0] r_cnt;

    assign cnt_o  = r_cnt;
    assign wrap_o = inc_i && (r_cnt == MaxVal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i) begin
            r_cnt <= (r_cnt == MaxVal) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster timing generator (pixel clock domain).
// Line order: active, front porch, sync, back porch; frames likewise in lines.
//   clk_i    : pixel clock
//   rst_ni   : asynchronous active-low reset
//   en_i     : advance enable, one pixel per enabled clock
//   hsync_o  : horizontal sync, asserted level HSyncPol
//   vsync_o  : vertical sync, asserted level VSyncPol
//   den_o    : data enable, high in the active region
//   x_o, y_o : current column / row
//   sol_o    : high while x == 0
//   sof_o    : high while x == 0 and y == 0
//   pix_o    : RGB888 colour bars, only with VIDEO_TIMING_GEN_PATTERN_EN defined
//
// FSM states
//   state  | meaning
//   S_IDLE | out of reset, counters parked at (0,0), waiting for first en_i
//   S_RUN  | raster running, counters advance on every en_i edge
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   CntWidth = 12,
    parameter int   HActive  = int'(VGA_640x480.h_active),
    parameter int   HFront   = int'(VGA_640x480.h_front),
    parameter int   HSync    = int'(VGA_640x480.h_sync),
    parameter int   HBack    = int'(VGA_640x480.h_back),
    parameter int   VActive  = int'(VGA_640x480.v_active),
    parameter int   VFront   = int'(VGA_640x480.v_front),
    parameter int   VSync    = int'(VGA_640x480.v_sync),
    parameter int   VBack    = int'(VGA_640x480.v_back),
    parameter logic HSyncPol = 1'b0,
    parameter logic VSyncPol = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                den_o,
    output logic [CntWidth-1:0] x_o,
    output logic [CntWidth-1:0] y_o,
    output logic                sol_o,
    output logic                sof_o
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    output logic [23:0]         pix_o
`endif
);

    localparam int HTotal = HActive + HFront + HSync + HBack;
    localparam int VTotal = VActive + VFront + VSync + VBack;

    // One extra bit so region bounds equal to 2^CntWidth still compare correctly.
    localparam int PW = CntWidth + 1;
    localparam logic [PW-1:0] HActEnd  = PW'(HActive);
    localparam logic [PW-1:0] HSyncBeg = PW'(HActive + HFront);
    localparam logic [PW-1:0] HSyncEnd = PW'(HActive + HFront + HSync);
    localparam logic [PW-1:0] VActEnd  = PW'(VActive);
    localparam logic [PW-1:0] VSyncBeg = PW'(VActive + VFront);
    localparam logic [PW-1:0] VSyncEnd = PW'(VActive + VFront + VSync);

    if (CntWidth < 1 || HActive < 1 || HFront < 1 || HSync < 1 || HBack < 1 ||
        VActive < 1 || VFront < 1 || VSync < 1 || VBack < 1) begin : g_chk_min
        $error("video_timing_gen: every size parameter must be at least 1");
    end
    if (longint'(HTotal) > (longint'(1) << CntWidth) ||
        longint'(VTotal) > (longint'(1) << CntWidth)) begin : g_chk_tot
        $error("video_timing_gen: HTotal/VTotal exceed 2^CntWidth");
    end

    vtg_state_e r_state;
    vtg_state_e w_state_nxt;
    logic       w_advance;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE && en_i) begin
            w_state_nxt = S_RUN;
        end
    end

    // The first enabled edge only leaves idle; it presents (0,0) without counting.
    always_comb begin
        w_advance = 1'b0;
        if (r_state == S_RUN) begin
            w_advance = en_i;
        end
    end

    logic [CntWidth-1:0] w_h_cnt;
    logic [CntWidth-1:0] w_v_cnt;
    logic                w_h_wrap;
    logic                w_v_wrap;

    wrap_counter #(.Width(CntWidth), .Max(HTotal - 1)) u_h_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_advance),
        .clr_i  (1'b0),
        .cnt_o  (w_h_cnt),
        .wrap_o (w_h_wrap)
    );

    wrap_counter #(.Width(CntWidth), .Max(VTotal - 1)) u_v_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_h_wrap),
        .clr_i  (1'b0),
        .cnt_o  (w_v_cnt),
        .wrap_o (w_v_wrap)
    );

    // Position the counters will hold after this edge; outputs are decoded from
    // it so the registered flags line up with the registered coordinates.
    logic [CntWidth-1:0] w_h_nxt;
    logic [CntWidth-1:0] w_v_nxt;
    logic [PW-1:0]       w_hx;
    logic [PW-1:0]       w_vx;
    logic                w_den_nxt;
    logic                w_hs_on;
    logic                w_vs_on;

    always_comb begin
        w_h_nxt = w_h_cnt;
        w_v_nxt = w_v_cnt;
        if (w_h_wrap) begin
            w_h_nxt = '0;
        end else if (w_advance) begin
            w_h_nxt = w_h_cnt + 1'b1;
        end
        if (w_v_wrap) begin
            w_v_nxt = '0;
        end else if (w_h_wrap) begin
            w_v_nxt = w_v_cnt + 1'b1;
        end
    end

    assign w_hx      = {1'b0, w_h_nxt};
    assign w_vx      = {1'b0, w_v_nxt};
    assign w_den_nxt = (w_hx < HActEnd) && (w_vx < VActEnd);
    assign w_hs_on   = (w_hx >= HSyncBeg) && (w_hx < HSyncEnd);
    assign w_vs_on   = (w_vx >= VSyncBeg) && (w_vx < VSyncEnd);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_o <= ~HSyncPol;
            vsync_o <= ~VSyncPol;
            den_o   <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
            sol_o   <= 1'b0;
            sof_o   <= 1'b0;
        end else if (en_i) begin
            hsync_o <= w_hs_on ? HSyncPol : ~HSyncPol;
            vsync_o <= w_vs_on ? VSyncPol : ~VSyncPol;
            den_o   <= w_den_nxt;
            x_o     <= w_h_nxt;
            y_o     <= w_v_nxt;
            sol_o   <= (w_h_nxt == '0);
            sof_o   <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    // Bar edges k*HActive/8 are constants; the last bar keeps any remainder.
    logic [2:0]  w_bar;
    logic [23:0] w_pix_nxt;

    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (w_hx >= PW'((k * HActive) / 8)) begin
                w_bar = 3'(k);
            end
        end
        w_pix_nxt = w_den_nxt ? bar_colour(w_bar) : 24'h000000;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_o <= '0;
        end else if (en_i) begin
            pix_o <= w_pix_nxt;
        end
    end
`endif

endmodule
